des_final_perm_stage: RTL

Output end of the DES datapath. It accepts the round-16 halves (L16, R16) from the round engine over a valid/ready handshake. It forms the preoutput R16||L16, applies the DES final permutation FP (IP^-1), and buffers the results in a small FIFO that drains to the downstream consumer over valid/ready. It is the inverse counterpart of the initial-permutation stage: FP(IP(x)) = x for every 64-bit x.

---
 rtl/des_final_perm_stage_if.sv | 13 +
 rtl/des_final_perm_stage.sv | 61 ++++++
 2 files changed

// File: rtl/des_final_perm_stage_if.sv
// des_final_perm_stage_if: input handshake, output handshake and occupancy of the DES output stage
interface des_final_perm_stage_if #(parameter int DEPTH = 2);
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              l16;
  logic [31:0]              r16;
  logic                     out_valid;
  logic                     out_ready;
  logic [63:0]              dat_out;
  logic [$clog2(DEPTH):0]   count;
  modport master (output in_valid, l16, r16, out_ready, input in_ready, out_valid, dat_out, count);
  modport slave  (input in_valid, l16, r16, out_ready, output in_ready, out_valid, dat_out, count);
endinterface

// File: rtl/des_final_perm_stage.sv
// des_final_perm_stage: swaps the round-16 halves, applies the DES final permutation and buffers results in a FIFO
module des_final_perm_stage #(
  parameter int DEPTH = 2,
  parameter bit SWAP  = 1'b1
) (
  input logic clk,
  input logic rst_n,
  des_final_perm_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // FP[i] is the DES bit of the preoutput feeding output DES bit i+1
  localparam int FP [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,
    39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,
    37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,
    35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,
    33, 1, 41,  9, 49, 17, 57, 25};
  logic [63:0]   w_pre;
  logic [63:0]   w_fp;
  logic          w_push;
  logic          w_pop;
  logic          w_in_ready;
  logic          w_out_valid;
  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  assign w_pre = SWAP ? {bus.r16, bus.l16} : {bus.l16, bus.r16};
  always_comb begin
    w_fp = '0;
    for (int i = 0; i < 64; i++) w_fp[6'(63 - i)] = w_pre[6'(64 - FP[i])];
  end
  // in_ready depends on occupancy only, so a full FIFO never accepts even if it pops this cycle
  assign w_in_ready    = r_count < CW'(DEPTH);
  assign w_out_valid   = r_count != '0;
  assign w_push        = bus.in_valid && w_in_ready;
  assign w_pop         = w_out_valid && bus.out_ready;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.dat_out   = r_mem[r_rd];
  assign bus.count     = r_count;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      for (int j = 0; j < DEPTH; j++) r_mem[j] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_fp;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule
